// File: rtl/sobel_ctrl_pkg.sv
// Shared types and constants for the sobel frame sequencer.
package sobel_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, PREP, KICK, RUN, READ} ctrl_state_e;

  localparam int unsigned ENG_RST_CYCLES_DEF = 2;
  localparam int unsigned TIMEOUT_W          = 32;

endpackage

// File: rtl/sobel_rd_fifo.sv
// Two-entry readout FIFO that also tracks one in-flight memory read so the
// issuer never requests more data than the FIFO can absorb.
module sobel_rd_fifo #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  can_issue,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  inflight;
  logic [1:0]            count;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  pop_ok;
  logic [DATA_WIDTH-1:0] mem [2];

  assign valid  = (count != 2'd0);
  assign pop_ok = pop && valid;
  assign data   = mem[rd_ptr];

  // A pop in this cycle frees a slot, which keeps readout at one pixel per cycle.
  assign can_issue = ({1'b0, count} + {2'b00, inflight}) < ({2'b00, pop_ok} + 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop_ok)   rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) mem[wr_ptr] <= rdata;
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around the sobel engine: load, engine reset/kick, run, readout.
// Optional RUN watchdog enabled by defining SOBEL_FRAME_TIMEOUT_EN.
module sobel_frame_ctrl
  import sobel_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned IN_PIXELS      = 4096,
  parameter int unsigned OUT_PIXELS     = 4096,
  parameter int unsigned ENG_RST_CYCLES = ENG_RST_CYCLES_DEF
`ifdef SOBEL_FRAME_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 65536
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_cmd_i,
  input  logic                  host_wr_valid_i,
  output logic                  host_wr_ready_o,
  input  logic [DATA_WIDTH-1:0] host_wr_data_i,
  output logic                  host_rd_valid_o,
  input  logic                  host_rd_ready_i,
  output logic [DATA_WIDTH-1:0] host_rd_data_o,
  output logic                  eng_rst_no,
  output logic                  eng_start_o,
  input  logic [ADDR_WIDTH-1:0] eng_i_addr_i,
  output logic [DATA_WIDTH-1:0] eng_i_pixel_o,
  input  logic                  eng_o_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] eng_o_addr_i,
  input  logic [DATA_WIDTH-1:0] eng_o_data_i,
  input  logic                  eng_finish_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [DATA_WIDTH-1:0] imem_wdata_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  omem_we_o,
  output logic [ADDR_WIDTH-1:0] omem_addr_o,
  output logic [DATA_WIDTH-1:0] omem_wdata_o,
  input  logic [DATA_WIDTH-1:0] omem_rdata_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IN   = ADDR_WIDTH'(IN_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_OUT  = ADDR_WIDTH'(OUT_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PREP = ADDR_WIDTH'(ENG_RST_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  ctrl_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0] load_cnt;
  logic [ADDR_WIDTH-1:0] prep_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] out_cnt;
  logic                  rd_done;
  logic                  wr_hs;
  logic                  rd_hs;
  logic                  issue;
  logic                  can_issue;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  timeout;

  assign wr_hs           = (state == LOAD) && host_wr_valid_i;
  assign host_rd_valid_o = (state == READ) && fifo_valid;
  assign host_rd_data_o  = host_rd_valid_o ? fifo_data : '0;
  assign rd_hs           = host_rd_valid_o && host_rd_ready_i;
  assign issue           = (state == READ) && !rd_done && can_issue;
  assign eng_i_pixel_o   = imem_rdata_i;
  assign busy_o          = (state != IDLE);
  assign eng_rst_no      = rst_ni && (state != PREP) && !timeout;

  sobel_rd_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .issue    (issue),
    .pop      (rd_hs),
    .rdata    (omem_rdata_i),
    .can_issue(can_issue),
    .valid    (fifo_valid),
    .data     (fifo_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    host_wr_ready_o = 1'b0;
    imem_we_o       = 1'b0;
    imem_addr_o     = '0;
    imem_wdata_o    = '0;
    omem_we_o       = 1'b0;
    omem_addr_o     = '0;
    omem_wdata_o    = '0;
    eng_start_o     = 1'b0;
    frame_done_o    = 1'b0;
    case (state)
      IDLE: if (load_cmd_i) state_nxt = LOAD;
      LOAD: begin
        host_wr_ready_o = 1'b1;
        imem_we_o       = host_wr_valid_i;
        imem_addr_o     = load_cnt;
        imem_wdata_o    = host_wr_data_i;
        if (wr_hs && (load_cnt == LAST_IN)) state_nxt = PREP;
      end
      PREP: if (prep_cnt == LAST_PREP) state_nxt = KICK;
      KICK: begin
        eng_start_o = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        imem_addr_o  = eng_i_addr_i;
        omem_we_o    = eng_o_wr_en_i;
        omem_addr_o  = eng_o_addr_i;
        omem_wdata_o = eng_o_data_i;
        if (eng_finish_i) begin
          frame_done_o = 1'b1;
          state_nxt    = READ;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        omem_addr_o = rd_addr;
        if (rd_hs && (out_cnt == LAST_OUT)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters sit at zero outside their own state, so each phase starts fresh.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      load_cnt <= '0;
      prep_cnt <= '0;
      rd_addr  <= '0;
      rd_done  <= 1'b0;
      out_cnt  <= '0;
    end else begin
      if (state == LOAD) begin
        if (wr_hs) load_cnt <= load_cnt + ADDR_ONE;
      end else begin
        load_cnt <= '0;
      end

      if (state == PREP) prep_cnt <= prep_cnt + ADDR_ONE;
      else               prep_cnt <= '0;

      if (state == READ) begin
        if (issue) begin
          if (rd_addr == LAST_OUT) rd_done <= 1'b1;
          else                     rd_addr <= rd_addr + ADDR_ONE;
        end
        if (rd_hs) out_cnt <= out_cnt + ADDR_ONE;
      end else begin
        rd_addr <= '0;
        rd_done <= 1'b0;
        out_cnt <= '0;
      end
    end
  end

`ifdef SOBEL_FRAME_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] run_cnt;
  logic                 error_q;

  // Finish has priority: a timeout only fires in a RUN cycle without finish.
  assign timeout = (state == RUN) && !eng_finish_i &&
                   (run_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign error_o = error_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      if (state == RUN) run_cnt <= run_cnt + TIMEOUT_W'(1);
      else              run_cnt <= '0;
      if ((state == IDLE) && load_cmd_i) error_q <= 1'b0;
      else if (timeout)                  error_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl with memory models and a scripted engine.
module tb_sobel_frame_ctrl;

  localparam int unsigned NPIX = 16;
  localparam int unsigned ERC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_cmd;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic        eng_rst_n;
  logic        eng_start;
  logic [15:0] eng_i_addr;
  logic [7:0]  eng_i_pixel;
  logic        eng_o_wr_en;
  logic [15:0] eng_o_addr;
  logic [7:0]  eng_o_data;
  logic        eng_finish;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic [7:0]  imem_rdata;
  logic        omem_we;
  logic [15:0] omem_addr;
  logic [7:0]  omem_wdata;
  logic [7:0]  omem_rdata;
  logic        busy;
  logic        frame_done;
  logic        error;

  logic [7:0] imem [65536];
  logic [7:0] omem [65536];
  logic [7:0] in_pix  [NPIX];
  logic [7:0] out_pix [NPIX];

  int compared   = 0;
  int mismatched = 0;
  int fd_cnt     = 0;
  int st_cnt     = 0;
  int st_base    = 0;

  always #5 clk = ~clk;

  sobel_frame_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (16),
    .IN_PIXELS     (NPIX),
    .OUT_PIXELS    (NPIX),
    .ENG_RST_CYCLES(ERC)
`ifdef SOBEL_FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_cmd_i     (load_cmd),
    .host_wr_valid_i(wr_valid),
    .host_wr_ready_o(wr_ready),
    .host_wr_data_i (wr_data),
    .host_rd_valid_o(rd_valid),
    .host_rd_ready_i(rd_ready),
    .host_rd_data_o (rd_data),
    .eng_rst_no     (eng_rst_n),
    .eng_start_o    (eng_start),
    .eng_i_addr_i   (eng_i_addr),
    .eng_i_pixel_o  (eng_i_pixel),
    .eng_o_wr_en_i  (eng_o_wr_en),
    .eng_o_addr_i   (eng_o_addr),
    .eng_o_data_i   (eng_o_data),
    .eng_finish_i   (eng_finish),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .imem_rdata_i   (imem_rdata),
    .omem_we_o      (omem_we),
    .omem_addr_o    (omem_addr),
    .omem_wdata_o   (omem_wdata),
    .omem_rdata_i   (omem_rdata),
    .busy_o         (busy),
    .frame_done_o   (frame_done),
    .error_o        (error)
  );

  // Synchronous-read memories with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= imem_wdata;
    imem_rdata <= imem[imem_addr];
    if (omem_we) omem[omem_addr] <= omem_wdata;
    omem_rdata <= omem[omem_addr];
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (eng_start === 1'b1)  st_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    compared++;
    if ({busy, wr_ready, rd_valid, eng_start, imem_we, omem_we, frame_done, error, eng_rst_n} !== 9'b0
        || rd_data !== 8'h00)
      begin mismatched++; $display("FAIL reset_outputs got=%b exp=0", {busy, wr_ready, rd_valid, eng_start, imem_we, omem_we, frame_done, error, eng_rst_n}); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (eng_rst_n !== 1'b1 || busy !== 1'b0)
      begin mismatched++; $display("FAIL reset_release eng_rst_n=%b busy=%b exp 1/0", eng_rst_n, busy); end
    cyc();
  endtask

  task automatic test_load(input bit ramp);
    int unsigned n = 0;
    int unsigned guard = 0;
    int unsigned nlow = 0;
    bit found = 1'b0;
    st_base = st_cnt;
    for (int i = 0; i < NPIX; i++) in_pix[i] = ramp ? 8'(i) : 8'($urandom);
    load_cmd = 1'b1;
    @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL load_idle busy=%b exp 0", busy); end
    cyc();
    load_cmd = 1'b0;
    while (n < NPIX && guard < 200) begin
      wr_valid = ramp ? 1'b1 : ($urandom_range(0, 2) != 0);
      wr_data  = wr_valid ? in_pix[n] : 8'($urandom);
      @(negedge clk);
      compared++;
      if ({wr_ready, imem_we, busy, rd_valid} !== {1'b1, wr_valid, 1'b1, 1'b0} ||
          (wr_valid && (imem_addr !== 16'(n) || imem_wdata !== in_pix[n])))
        begin mismatched++; $display("FAIL load_beat n=%0d rdy/we/busy/rv=%b addr=%0d exp addr=%0d", n, {wr_ready, imem_we, busy, rd_valid}, imem_addr, n); end
      cyc();
      if (wr_valid) n++;
      guard++;
    end
    wr_valid = 1'b0;
    compared++;
    if (n != NPIX) begin mismatched++; $display("FAIL load_count got=%0d exp=%0d", n, NPIX); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (eng_start === 1'b1) begin found = 1'b1; break; end
      if (eng_rst_n === 1'b0) nlow++;
      cyc();
    end
    compared++;
    if (!found || nlow != ERC)
      begin mismatched++; $display("FAIL prep_kick start_seen=%b rst_low_cycles=%0d exp 1/%0d", found, nlow, ERC); end
    compared++;
    if (eng_rst_n !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b1)
      begin mismatched++; $display("FAIL kick_state eng_rst_n=%b wr_ready=%b busy=%b exp 1/0/1", eng_rst_n, wr_ready, busy); end
    cyc();
    for (int i = 0; i < NPIX; i++) begin
      compared++;
      if (imem[i] !== in_pix[i]) begin mismatched++; $display("FAIL imem_content addr=%0d got=%h exp=%h", i, imem[i], in_pix[i]); end
    end
  endtask

  task automatic test_run(input bit ramp, input bit poke_cmd);
    int fd_base = fd_cnt;
    for (int a = 0; a < NPIX; a++)
      out_pix[a] = (ramp && a == 3) ? 8'hFF : (ramp && a == NPIX - 1) ? 8'h00 : 8'($urandom);
    for (int a = 0; a < NPIX; a++) begin
      eng_i_addr  = 16'(a);
      eng_o_wr_en = 1'b0;
      eng_finish  = 1'b0;
      load_cmd    = poke_cmd && (a == 2);
      @(negedge clk);
      compared++;
      if (imem_addr !== 16'(a) || imem_we !== 1'b0 || omem_we !== 1'b0 || busy !== 1'b1)
        begin mismatched++; $display("FAIL run_iaddr a=%0d got=%0d we=%b/%b busy=%b", a, imem_addr, imem_we, omem_we, busy); end
      cyc();
      load_cmd    = 1'b0;
      eng_o_wr_en = 1'b1;
      eng_o_addr  = 16'(a);
      eng_o_data  = out_pix[a];
      eng_finish  = (a == NPIX - 1);
      @(negedge clk);
      compared++;
      if (eng_i_pixel !== in_pix[a])
        begin mismatched++; $display("FAIL run_pixel a=%0d got=%h exp=%h", a, eng_i_pixel, in_pix[a]); end
      compared++;
      if ({omem_we, omem_addr, omem_wdata, wr_ready} !== {1'b1, 16'(a), out_pix[a], 1'b0})
        begin mismatched++; $display("FAIL run_owrite a=%0d we=%b addr=%0d data=%h exp addr=%0d data=%h", a, omem_we, omem_addr, omem_wdata, a, out_pix[a]); end
      compared++;
      if (frame_done !== (a == NPIX - 1))
        begin mismatched++; $display("FAIL run_done a=%0d got=%b", a, frame_done); end
      cyc();
    end
    eng_o_wr_en = 1'b0;
    eng_finish  = 1'b0;
    compared++;
    if (fd_cnt - fd_base != 1 || st_cnt - st_base != 1)
      begin mismatched++; $display("FAIL run_pulses done=%0d start=%0d exp 1/1", fd_cnt - fd_base, st_cnt - st_base); end
  endtask

  task automatic test_read(input int mode);
    int n = 0;
    int first = -1;
    int last = -1;
    bit stall = 1'b0;
    bit rdy;
    logic [7:0] held = 8'h00;
    for (int k = 0; k < 200 && n < NPIX; k++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 4 == 0) || (k % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy;
      @(negedge clk);
      compared++;
      if (imem_we !== 1'b0 || omem_we !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0)
        begin mismatched++; $display("FAIL read_ctrl k=%0d we=%b/%b busy=%b done=%b", k, imem_we, omem_we, busy, frame_done); end
      if (stall) begin
        compared++;
        if (rd_valid !== 1'b1 || rd_data !== held)
          begin mismatched++; $display("FAIL read_stable k=%0d valid=%b data=%h exp 1/%h", k, rd_valid, rd_data, held); end
      end
      stall = 1'b0;
      if (rd_valid === 1'b1) begin
        if (first < 0) first = k;
        if (rdy) begin
          compared++;
          if (rd_data !== out_pix[n])
            begin mismatched++; $display("FAIL read_data n=%0d got=%h exp=%h", n, rd_data, out_pix[n]); end
          n++;
          last = k;
        end else begin
          stall = 1'b1;
          held  = rd_data;
        end
      end
      cyc();
    end
    rd_ready = 1'b0;
    compared++;
    if (n != NPIX) begin mismatched++; $display("FAIL read_count got=%0d exp=%0d", n, NPIX); end
    compared++;
    if (first != 2) begin mismatched++; $display("FAIL read_latency got=%0d exp=2", first); end
    if (mode == 0) begin
      compared++;
      if (last != 2 + int'(NPIX) - 1) begin mismatched++; $display("FAIL read_throughput last=%0d exp=%0d", last, 1 + NPIX); end
    end
    @(negedge clk);
    compared++;
    if (busy !== 1'b0 || rd_valid !== 1'b0)
      begin mismatched++; $display("FAIL read_end busy=%b valid=%b exp 0/0", busy, rd_valid); end
    cyc();
  endtask

  task automatic test_midframe_reset();
    load_cmd = 1'b1;
    cyc();
    load_cmd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      cyc();
    end
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    compared++;
    if (imem_addr !== 16'd7 || eng_rst_n !== 1'b0)
      begin mismatched++; $display("FAIL midrst_pre addr=%0d eng_rst_n=%b exp 7/0", imem_addr, eng_rst_n); end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy, wr_ready, rd_valid, eng_start, imem_we, omem_we, frame_done, error} !== 8'b0 || eng_rst_n !== 1'b1)
      begin mismatched++; $display("FAIL midrst_post outs=%b eng_rst_n=%b exp 0/1", {busy, wr_ready, rd_valid, eng_start, imem_we, omem_we, frame_done, error}, eng_rst_n); end
    cyc();
    test_load(1'b0);
    test_run(1'b0, 1'b0);
    test_read(0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      test_load(1'b0);
      test_run(1'b0, 1'b1);
      test_read(2);
    end
  endtask

`ifdef SOBEL_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    int fd_base;
    test_load(1'b0);
    fd_base = fd_cnt;
    for (int k = 1; k <= 51; k++) begin
      eng_i_addr = 16'($urandom_range(0, NPIX - 1));
      @(negedge clk);
      if (k == 49) begin
        compared++;
        if (busy !== 1'b1 || eng_rst_n !== 1'b1 || error !== 1'b0)
          begin mismatched++; $display("FAIL to_before busy=%b rst=%b err=%b exp 1/1/0", busy, eng_rst_n, error); end
      end
      if (k == 50) begin
        compared++;
        if (eng_rst_n !== 1'b0 || busy !== 1'b1)
          begin mismatched++; $display("FAIL to_fire rst=%b busy=%b exp 0/1", eng_rst_n, busy); end
      end
      if (k == 51) begin
        compared++;
        if (busy !== 1'b0 || error !== 1'b1 || rd_valid !== 1'b0)
          begin mismatched++; $display("FAIL to_after busy=%b err=%b valid=%b exp 0/1/0", busy, error, rd_valid); end
      end
      cyc();
    end
    compared++;
    if (fd_cnt != fd_base) begin mismatched++; $display("FAIL to_no_done got=%0d exp=0", fd_cnt - fd_base); end
    @(negedge clk);
    compared++;
    if (error !== 1'b1) begin mismatched++; $display("FAIL to_sticky err=%b exp 1", error); end
    cyc();
    test_load(1'b0);
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("FAIL to_clear err=%b exp 0", error); end
    test_run(1'b0, 1'b0);
    test_read(2);
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    load_cmd    = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = 8'h00;
    rd_ready    = 1'b0;
    eng_i_addr  = 16'h0;
    eng_o_wr_en = 1'b0;
    eng_o_addr  = 16'h0;
    eng_o_data  = 8'h00;
    eng_finish  = 1'b0;
    test_reset();
    test_load(1'b1);
    test_run(1'b1, 1'b1);
    test_read(1);
    test_midframe_reset();
    test_back_to_back();
`ifdef SOBEL_FRAME_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
